divisor_sequencial: RTL and testbench
=====================================

Name: divisor_sequencial

Overview:
- Sequential restoring (shift-subtract) unsigned divider; the inverse datapath of the team's shift-add multiplier.
- Uses the same St/Idle/Done handshake as the multiplier so the ALU sequencer drives both identically.
- Computes one quotient bit per clock over N iterations.
- Sits beside the multiplier in the RISC execution unit and is selected by the sequencer for DIV/REM.

Parameters:
- N, 16, operand width: dividend, divisor, quotient and remainder are all N bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Dividendo  input  N  dividend; sampled only on the start edge
- Divisor  input  N  divisor; sampled only on the start edge
- St  input  1  start request; honoured only while Idle=1
- Quociente  output  N  quotient; registered
- Resto  output  N  remainder; registered
- Idle  output  1  high while in IDLE state; combinational from state
- Done  output  1  one-cycle pulse when results become valid
- DivZero  output  1  divide-by-zero flag; registered

Behaviour:
- Reset (synchronous): state=IDLE; Quociente=0, Resto=0, Done=0, DivZero=0; iteration counter=0. A reset mid-operation aborts the division, returns to IDLE and clears all outputs on that same edge.
- States: IDLE, CALC, FIM.
- IDLE: Idle=1. On an edge with St=1:
  - latch M=Divisor, Q=Dividendo, A=0 (A is N+1 bits);
  - counter K=0;
  - go to CALC.
  - With St=0, stay in IDLE; outputs hold their last results.
- CALC: one iteration per edge.
  - {A,Q} shifted left 1.
  - T = A_shifted - {1'b0,M}, computed at N+1 bits.
  - If T[N]=1 (negative): A=A_shifted, Q[0]=0 (restore).
  - Else: A=T, Q[0]=1.
  - K increments each edge. Internal signal K_last=1 when K==N-1.
  - The edge that performs iteration N-1 loads Quociente=Q_new and Resto=A_new[N-1:0], sets Done=1 and goes to FIM.
- FIM: Done=1 for exactly this cycle. Next edge: Done=0, go to IDLE.
- Latency: St sampled at edge t0 -> Done high between edges tN and tN+1. Idle returns at tN+1. For N=16, start-to-start minimum is 18 cycles.
- St while in CALC or FIM is ignored; it is not queued. Operand changes after t0 have no effect.
- Quociente, Resto and DivZero hold until the next start's Done edge or a reset.
- Divisor=0 without the optional feature: the algorithm runs its normal N iterations. Result: Quociente=all ones, Resto=Dividendo, DivZero=0.
- All arithmetic is unsigned; no signed handling in this block.

Optional Feature:
- Macro: DIVISOR_DIVZERO_DETECT_EN
- Defined, Divisor=0 at the start edge:
  - skip CALC and go directly IDLE->FIM;
  - load Quociente={N{1'b1}}, Resto=Dividendo, DivZero=1 on that edge;
  - Done pulses on the following cycle (latency 1).
  - Any non-zero-divisor division clears DivZero=0 when its results load.
- Undefined: no zero detection; DivZero is tied 0; timing is always N iterations.

Decomposition:
- Shared package divisor_pkg:
  - width default N=16;
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_FIM=2'd2;
  - counter width $clog2(N).
- One sub-module: divisor_passo, the combinational single iteration.
  - Inputs: A, Q, M.
  - Outputs: A_new, Q_new.
  - Instantiated once in the CALC datapath.
- Control FSM and registers stay in divisor_sequencial.

Test Plan:
- Reset 2 cycles, then start 7/7 -> Done after 16 iterations; Quociente=1, Resto=0; Idle=1 next cycle.
- 100/7 -> Quociente=14, Resto=2. 0/1234 -> 0 r0. 65535/3 -> 21845 r0. 30000/4000 -> 7 r2000.
- 1234/0, macro undefined -> 65535 r1234 after 16 iterations, DivZero=0. Macro defined -> same values, DivZero=1, Done one cycle after start.
- Start 1000/10, change operands to 5/5 and pulse St during CALC -> St ignored; result 100 r0; exactly one Done pulse.
- Start 500/3, assert rst at iteration 8 -> next edge Idle=1, Quociente=0, Resto=0, Done never pulses. A new 9/4 then yields 2 r1.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider (divisor_sequencial).
package divisor_pkg;

  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIM  = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit so tiny N still elaborates.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KW_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/divisor_passo.sv
// One combinational shift-subtract-restore step of the unsigned restoring divider.
module divisor_passo
  import divisor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   A,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] M,
  output logic [N:0]   A_new,
  output logic [N-1:0] Q_new
);

  logic [N:0] aShift;
  logic [N:0] trial;

  // A stays below M between steps, so its top bit is always zero and can be dropped by the shift.
  assign aShift = {A[N-1:0], Q[N-1]};
  assign trial  = aShift - {1'b0, M};

  always_comb begin
    A_new = aShift;
    Q_new = {Q[N-2:0], 1'b0};
    if (!trial[N]) begin
      A_new = trial;
      Q_new = {Q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring unsigned divider with St/Idle/Done handshake, one quotient bit per clock.
// Optional divide-by-zero shortcut enabled by defining DIVISOR_DIVZERO_DETECT_EN.
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic [N-1:0] Dividendo,
  input  logic [N-1:0] Divisor,
  input  logic         St,
  output logic [N-1:0] Quociente,
  output logic [N-1:0] Resto,
  output logic         Idle,
  output logic         Done,
  output logic         DivZero
);

  localparam int KW = cnt_width(N);
  localparam logic [KW-1:0] K_MAX = KW'(N - 1);

  state_t        state_q;
  logic [N:0]    a_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  m_q;
  logic [KW-1:0] k_q;
  logic [N-1:0]  quoc_q;
  logic [N-1:0]  resto_q;
  logic          done_q;
  logic [N:0]    a_d;
  logic [N-1:0]  q_d;
  logic          kLast;

  divisor_passo #(.N(N)) u_passo (
    .A    (a_q),
    .Q    (q_q),
    .M    (m_q),
    .A_new(a_d),
    .Q_new(q_d)
  );

  assign kLast = (k_q == K_MAX);

`ifdef DIVISOR_DIVZERO_DETECT_EN
  logic divzero_q;
  assign DivZero = divzero_q;
`else
  assign DivZero = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      quoc_q  <= '0;
      resto_q <= '0;
      done_q  <= 1'b0;
`ifdef DIVISOR_DIVZERO_DETECT_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (St) begin
`ifdef DIVISOR_DIVZERO_DETECT_EN
            // Zero divisor bypasses the iterations and publishes the same values the loop would produce.
            if (Divisor == '0) begin
              quoc_q    <= '1;
              resto_q   <= Dividendo;
              divzero_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_FIM;
            end else begin
              m_q     <= Divisor;
              q_q     <= Dividendo;
              a_q     <= '0;
              k_q     <= '0;
              state_q <= S_CALC;
            end
`else
            m_q     <= Divisor;
            q_q     <= Dividendo;
            a_q     <= '0;
            k_q     <= '0;
            state_q <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          a_q <= a_d;
          q_q <= q_d;
          k_q <= k_q + KW'(1);
          if (kLast) begin
            quoc_q  <= q_d;
            resto_q <= a_d[N-1:0];
            done_q  <= 1'b1;
`ifdef DIVISOR_DIVZERO_DETECT_EN
            divzero_q <= 1'b0;
`endif
            state_q <= S_FIM;
          end
        end
        S_FIM: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Idle      = (state_q == S_IDLE);
  assign Done      = done_q;
  assign Quociente = quoc_q;
  assign Resto     = resto_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed cases, random operands against an arithmetic model,
// St-during-CALC, mid-operation reset and back-to-back starts. Honours DIVISOR_DIVZERO_DETECT_EN.
module tb_divisor_sequencial;

  localparam int N = 16;
  localparam int LAT_NORMAL = N;
  localparam int MAX_WAIT = 40;

  logic         Clk;
  logic         rst;
  logic [N-1:0] Dividendo;
  logic [N-1:0] Divisor;
  logic         St;
  logic [N-1:0] Quociente;
  logic [N-1:0] Resto;
  logic         Idle;
  logic         Done;
  logic         DivZero;

  int checks = 0;
  int errors = 0;

  divisor_sequencial #(.N(N)) dut (
    .Clk      (Clk),
    .rst      (rst),
    .Dividendo(Dividendo),
    .Divisor  (Divisor),
    .St       (St),
    .Quociente(Quociente),
    .Resto    (Resto),
    .Idle     (Idle),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain unsigned arithmetic, zero divisor yields all ones / dividend.
  function automatic logic [N-1:0] model_q(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? {N{1'b1}} : a / b;
  endfunction

  function automatic logic [N-1:0] model_r(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic logic model_dz(input logic [N-1:0] b);
`ifdef DIVISOR_DIVZERO_DETECT_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input logic [N-1:0] b);
`ifdef DIVISOR_DIVZERO_DETECT_EN
    return (b == 0) ? 0 : LAT_NORMAL;
`else
    return LAT_NORMAL;
`endif
  endfunction

  // Runs one division; lat counts clock edges after the start edge until Done is seen (-1 on timeout).
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit aligned,
                        input bit scramble, output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic dz, output int lat, output logic doneAfter,
                        output logic idleAfter);
    if (!aligned) @(negedge Clk);
    Dividendo = a;
    Divisor   = b;
    St        = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    if (scramble) begin
      Dividendo = N'($urandom);
      Divisor   = N'($urandom);
    end
    lat = 0;
    while (Done !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
    end
    if (Done !== 1'b1) lat = -1;
    q  = Quociente;
    r  = Resto;
    dz = DivZero;
    @(posedge Clk);
    @(negedge Clk);
    doneAfter = Done;
    idleAfter = Idle;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    rst = 1'b1;
    St  = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Idle, Done, DivZero, Quociente, Resto} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}}) begin
      errors++;
      $display("[TB] FAIL reset: Idle=%b Done=%b DivZero=%b Q=%0d R=%0d, required 1 0 0 0 0",
               Idle, Done, DivZero, Quociente, Resto);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] da[6] = '{16'd7, 16'd100, 16'd0, 16'd65535, 16'd30000, 16'd1234};
    logic [N-1:0] db[6] = '{16'd7, 16'd7, 16'd1234, 16'd3, 16'd4000, 16'd0};
    logic [N-1:0] eq[6] = '{16'd1, 16'd14, 16'd0, 16'd21845, 16'd7, 16'd65535};
    logic [N-1:0] er[6] = '{16'd0, 16'd2, 16'd0, 16'd0, 16'd2000, 16'd1234};
    logic [N-1:0] q, r;
    logic dz, dA, iA;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_div(da[i], db[i], 1'b0, 1'b0, q, r, dz, lat, dA, iA);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        errors++;
        $display("[TB] FAIL directed %0d/%0d result: got %0d r%0d, required %0d r%0d",
                 da[i], db[i], q, r, eq[i], er[i]);
      end
      checks++;
      if (lat !== model_lat(db[i]) || dz !== model_dz(db[i])) begin
        errors++;
        $display("[TB] FAIL directed %0d/%0d timing: lat=%0d dz=%b, required lat=%0d dz=%b",
                 da[i], db[i], lat, dz, model_lat(db[i]), model_dz(db[i]));
      end
      checks++;
      if (dA !== 1'b0 || iA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed %0d/%0d handshake: Done=%b Idle=%b after pulse, required 0 1",
                 da[i], db[i], dA, iA);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, r;
    logic dz, dA, iA;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case (i % 4)
        0: b = N'($urandom_range(1, 15));
        1: b = N'($urandom);
        2: b = (i % 10 == 2) ? '0 : N'($urandom_range(1, 300));
        default: b = (i % 8 == 3) ? '0 : N'($urandom);
      endcase
      do_div(a, b, 1'b0, 1'b1, q, r, dz, lat, dA, iA);
      checks++;
      if (q !== model_q(a, b) || r !== model_r(a, b) || dz !== model_dz(b) ||
          lat !== model_lat(b) || dA !== 1'b0 || iA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random %0d/%0d: got %0d r%0d dz=%b lat=%0d Done=%b Idle=%b, required %0d r%0d dz=%b lat=%0d 0 1",
                 a, b, q, r, dz, lat, dA, iA, model_q(a, b), model_r(a, b), model_dz(b), model_lat(b));
      end
    end
  endtask

  task automatic test_st_ignored();
    int pulses = 0;
    int firstAt = -1;
    logic [N-1:0] q = '0, r = '0;
    @(negedge Clk);
    Dividendo = 16'd1000;
    Divisor   = 16'd10;
    St        = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 4) begin
        Dividendo = 16'd5;
        Divisor   = 16'd5;
        St        = 1'b1;
      end else begin
        St = 1'b0;
      end
      if (Done === 1'b1) begin
        pulses++;
        if (firstAt < 0) begin
          firstAt = c - 1;
          q = Quociente;
          r = Resto;
        end
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    St = 1'b0;
    checks++;
    if (pulses !== 1 || firstAt !== LAT_NORMAL) begin
      errors++;
      $display("[TB] FAIL st_ignored pulses: %0d pulses first at %0d, required 1 at %0d",
               pulses, firstAt, LAT_NORMAL);
    end
    checks++;
    if (q !== 16'd100 || r !== 16'd0) begin
      errors++;
      $display("[TB] FAIL st_ignored result: got %0d r%0d, required 100 r0", q, r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [N-1:0] q, r;
    logic dz, dA, iA;
    int lat;
    @(negedge Clk);
    Dividendo = 16'd500;
    Divisor   = 16'd3;
    St        = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    repeat (8) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (Idle !== 1'b1 || Quociente !== '0 || Resto !== '0 || Done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid state: Idle=%b Q=%0d R=%0d Done=%b, required 1 0 0 0",
               Idle, Quociente, Resto, Done);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (Done === 1'b1) pulses++;
      @(posedge Clk);
      @(negedge Clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid done: %0d Done pulses after abort, required 0", pulses);
    end
    do_div(16'd9, 16'd4, 1'b1, 1'b0, q, r, dz, lat, dA, iA);
    checks++;
    if (q !== 16'd2 || r !== 16'd1 || lat !== LAT_NORMAL) begin
      errors++;
      $display("[TB] FAIL reset_mid restart: got %0d r%0d lat=%0d, required 2 r1 lat=%0d",
               q, r, lat, LAT_NORMAL);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, q, r;
    logic dz, dA, iA;
    int lat;
    do_div(16'd12345, 16'd77, 1'b0, 1'b0, q, r, dz, lat, dA, iA);
    for (int i = 0; i < 6; i++) begin
      a = N'($urandom);
      b = (i == 3) ? '0 : N'($urandom_range(1, 65535));
      do_div(a, b, 1'b1, 1'b0, q, r, dz, lat, dA, iA);
      checks++;
      if (q !== model_q(a, b) || r !== model_r(a, b) || dz !== model_dz(b) ||
          lat !== model_lat(b) || iA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back %0d/%0d: got %0d r%0d dz=%b lat=%0d Idle=%b, required %0d r%0d dz=%b lat=%0d 1",
                 a, b, q, r, dz, lat, iA, model_q(a, b), model_r(a, b), model_dz(b), model_lat(b));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    St        = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    test_reset();
    test_directed();
    test_random();
    test_st_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
